wb_arbiter_n: RTL and testbench

Parametrised N-port Wishbone classic arbiter that connects PORTS masters to one slave. It is the generalised successor of the fixed two-port arbiter. Arbitration is self-contained with a registered grant, and supports fixed-priority or round-robin selection with zero-bubble handoff. It adds a per-transfer watchdog that terminates a stalled slave access with ERR. It sits between CPU/DMA masters and a shared interconnect or slave port.

---
 rtl/wb_arbiter_n.sv | 165 ++++++++++++++++
 tb/tb_wb_arbiter_n.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_n.sv
// N-port Wishbone classic arbiter with a registered one-hot grant, fixed-priority or
// round-robin selection with zero-bubble handoff, and an optional stalled-strobe watchdog.
module wb_arbiter_n #(
   parameter int PORTS                 = 4,
   parameter int DATA_WIDTH            = 32,
   parameter int ADDR_WIDTH            = 32,
   parameter int SELECT_WIDTH          = DATA_WIDTH / 8,
   parameter int ARB_TYPE_ROUND_ROBIN  = 0,
   parameter int ARB_LSB_HIGH_PRIORITY = 1,
   parameter int TIMEOUT               = 0
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [PORTS*ADDR_WIDTH-1:0]     wbm_adr_i,
   input  logic [PORTS*DATA_WIDTH-1:0]     wbm_dat_i,
   output logic [PORTS*DATA_WIDTH-1:0]     wbm_dat_o,
   input  logic [PORTS-1:0]                wbm_we_i,
   input  logic [PORTS*SELECT_WIDTH-1:0]   wbm_sel_i,
   input  logic [PORTS-1:0]                wbm_stb_i,
   output logic [PORTS-1:0]                wbm_ack_o,
   output logic [PORTS-1:0]                wbm_err_o,
   output logic [PORTS-1:0]                wbm_rty_o,
   input  logic [PORTS-1:0]                wbm_cyc_i,
   output logic [ADDR_WIDTH-1:0]           wbs_adr_o,
   input  logic [DATA_WIDTH-1:0]           wbs_dat_i,
   output logic [DATA_WIDTH-1:0]           wbs_dat_o,
   output logic                            wbs_we_o,
   output logic [SELECT_WIDTH-1:0]         wbs_sel_o,
   output logic                            wbs_stb_o,
   input  logic                            wbs_ack_i,
   input  logic                            wbs_err_i,
   input  logic                            wbs_rty_i,
   output logic                            wbs_cyc_o,
   output logic [PORTS-1:0]                grant_o,
   output logic                            timeout_o
);

   localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [PORTS-1:0]        grant_q, grant_d;
   logic [PW-1:0]           ptr_q, ptr_d;
   logic [CW-1:0]           count_q, count_d;

   logic                    pick_valid;
   logic [PW-1:0]           pick_idx;
   logic [PW-1:0]           cand;
   logic                    rearb;
   logic                    stb_sel;
   logic                    we_sel;
   logic                    term;
   logic                    fire;
   logic [ADDR_WIDTH-1:0]   adr_sel;
   logic [DATA_WIDTH-1:0]   dat_sel;
   logic [SELECT_WIDTH-1:0] sel_sel;

   // ptr_q holds the index searched first; it always sits one step past the last grant.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 0; k < PORTS; k++) begin
         if (ARB_TYPE_ROUND_ROBIN != 0) begin
            if (ARB_LSB_HIGH_PRIORITY != 0) begin
               cand = PW'((int'(ptr_q) + k) % PORTS);
            end else begin
               cand = PW'((int'(ptr_q) + PORTS - k) % PORTS);
            end
         end else begin
            cand = (ARB_LSB_HIGH_PRIORITY != 0) ? PW'(k) : PW'(PORTS - 1 - k);
         end
         if (!pick_valid && wbm_cyc_i[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      rearb   = 1'b0;
      case (state_q)
         IDLE:    rearb = 1'b1;
         GRANTED: rearb = ((grant_q & wbm_cyc_i) == '0);
         default: rearb = 1'b1;
      endcase
      if (rearb) begin
         if (pick_valid) begin
            state_d = GRANTED;
            grant_d = PORTS'(1) << pick_idx;
            if (ARB_LSB_HIGH_PRIORITY != 0) begin
               ptr_d = (pick_idx == PW'(PORTS - 1)) ? '0 : pick_idx + 1'b1;
            end else begin
               ptr_d = (pick_idx == '0) ? PW'(PORTS - 1) : pick_idx - 1'b1;
            end
         end else begin
            state_d = IDLE;
            grant_d = '0;
         end
      end
   end

   always_comb begin
      adr_sel = '0;
      dat_sel = '0;
      sel_sel = '0;
      for (int k = 0; k < PORTS; k++) begin
         if (grant_q[k]) begin
            adr_sel = wbm_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            dat_sel = wbm_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
            sel_sel = wbm_sel_i[k*SELECT_WIDTH +: SELECT_WIDTH];
         end
      end
   end

   assign stb_sel = |(grant_q & wbm_stb_i);
   assign we_sel  = |(grant_q & wbm_we_i);
   assign term    = wbs_ack_i | wbs_err_i | wbs_rty_i;

   // The fire cycle follows TIMEOUT unterminated strobe cycles; the slave never sees it.
   assign fire = (TIMEOUT > 0) && stb_sel && (count_q == CW'(TIMEOUT));

   always_comb begin
      count_d = count_q + 1'b1;
      if ((TIMEOUT == 0) || (grant_d != grant_q) || fire || !wbs_stb_o || term) begin
         count_d = '0;
      end
   end

   assign wbs_adr_o = adr_sel;
   assign wbs_dat_o = dat_sel;
   assign wbs_sel_o = sel_sel;
   assign wbs_we_o  = we_sel;
   assign wbs_stb_o = stb_sel & ~fire;
   assign wbs_cyc_o = |grant_q;
   assign wbm_dat_o = {PORTS{wbs_dat_i}};
   assign wbm_ack_o = grant_q & {PORTS{wbs_ack_i & ~fire}};
   assign wbm_err_o = grant_q & {PORTS{(wbs_err_i & ~fire) | fire}};
   assign wbm_rty_o = grant_q & {PORTS{wbs_rty_i & ~fire}};
   assign grant_o   = grant_q;
   assign timeout_o = fire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Bench for wb_arbiter_n: a round-robin instance with an 8-cycle watchdog and a
// fixed-priority instance without one, both checked against a queue-level grant model.
module tb_wb_arbiter_n;

   localparam int P  = 4;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int SW = 4;
   localparam int TO = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic [P*AW-1:0]   m_adr;
   logic [P*DW-1:0]   m_dat;
   logic [P-1:0]      m_we, m_stb, m_cyc;
   logic [P*SW-1:0]   m_sel;
   logic [DW-1:0]     s_dat;
   logic              s_ack, s_err, s_rty;

   logic [P*DW-1:0]   r_mdat, f_mdat;
   logic [P-1:0]      r_ack, r_err, r_rty, r_grant;
   logic [P-1:0]      f_ack, f_err, f_rty, f_grant;
   logic [AW-1:0]     r_adr, f_adr;
   logic [DW-1:0]     r_sdat, f_sdat;
   logic [SW-1:0]     r_sel, f_sel;
   logic              r_we, r_stb, r_cyc, r_to;
   logic              f_we, f_stb, f_cyc, f_to;

   wb_arbiter_n #(.PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
                  .ARB_TYPE_ROUND_ROBIN(1), .ARB_LSB_HIGH_PRIORITY(1), .TIMEOUT(TO)) dut_rr (
      .clk(clk), .rst_n(rst_n),
      .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_dat_o(r_mdat), .wbm_we_i(m_we),
      .wbm_sel_i(m_sel), .wbm_stb_i(m_stb), .wbm_ack_o(r_ack), .wbm_err_o(r_err),
      .wbm_rty_o(r_rty), .wbm_cyc_i(m_cyc),
      .wbs_adr_o(r_adr), .wbs_dat_i(s_dat), .wbs_dat_o(r_sdat), .wbs_we_o(r_we),
      .wbs_sel_o(r_sel), .wbs_stb_o(r_stb), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
      .wbs_rty_i(s_rty), .wbs_cyc_o(r_cyc), .grant_o(r_grant), .timeout_o(r_to)
   );

   wb_arbiter_n #(.PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
                  .ARB_TYPE_ROUND_ROBIN(0), .ARB_LSB_HIGH_PRIORITY(1), .TIMEOUT(0)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_dat_o(f_mdat), .wbm_we_i(m_we),
      .wbm_sel_i(m_sel), .wbm_stb_i(m_stb), .wbm_ack_o(f_ack), .wbm_err_o(f_err),
      .wbm_rty_o(f_rty), .wbm_cyc_i(m_cyc),
      .wbs_adr_o(f_adr), .wbs_dat_i(s_dat), .wbs_dat_o(f_sdat), .wbs_we_o(f_we),
      .wbs_sel_o(f_sel), .wbs_stb_o(f_stb), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
      .wbs_rty_i(s_rty), .wbs_cyc_o(f_cyc), .grant_o(f_grant), .timeout_o(f_to)
   );

   int total = 0;
   int bad   = 0;
   int g_rr, last_rr, g_fp;

   function automatic logic [P-1:0] onehot(input int g);
      logic [P-1:0] v;
      for (int k = 0; k < P; k++) v[k] = (k == g);
      return v;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      g_rr    = -1;
      last_rr = P - 1;
      g_fp    = -1;
   endtask

   // Grants move only when idle or when the holder's cyc was low at this edge.
   task automatic model_update();
      if (g_rr < 0 || !m_cyc[g_rr]) begin
         g_rr = -1;
         for (int k = P; k >= 1; k--) begin
            int c;
            c = (last_rr + k) % P;
            if (m_cyc[c]) g_rr = c;
         end
         if (g_rr >= 0) last_rr = g_rr;
      end
      if (g_fp < 0 || !m_cyc[g_fp]) begin
         g_fp = -1;
         for (int k = P - 1; k >= 0; k--) if (m_cyc[k]) g_fp = k;
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_update();
      #1;
   endtask

   task automatic check_grants(input string tag);
      #2;
      chk({tag, "_rr_grant"}, 128'(r_grant), 128'(onehot(g_rr)));
      chk({tag, "_fp_grant"}, 128'(f_grant), 128'(onehot(g_fp)));
      chk({tag, "_rr_cyc"}, 128'(r_cyc), 128'(g_rr >= 0));
      chk({tag, "_fp_cyc"}, 128'(f_cyc), 128'(g_fp >= 0));
   endtask

   logic [P-1:0] done;
   int           lat;
   bit           lat_armed;
   int           r;
   logic [AW-1:0] exp_adr;
   logic [DW-1:0] exp_dat;
   logic          exp_stb;

   initial begin
      rst_n = 1'b0;
      m_adr = '0; m_dat = '0; m_we = '0; m_sel = '0; m_stb = '0; m_cyc = '0;
      s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
      model_reset();

      step();
      step();
      check_grants("reset");
      chk("reset_grant", 128'(r_grant), 128'(0));
      chk("reset_timeout", 128'(r_to), 128'(0));
      chk("reset_stb", 128'(r_stb), 128'(0));
      chk("reset_adr", 128'(r_adr), 128'(0));
      chk("reset_acks", 128'({r_ack, r_err, r_rty}), 128'(0));
      rst_n = 1'b1;

      // Round robin: 0,1,2 request, single-cycle transfers, one drop cycle each.
      m_cyc = 4'b0111; m_stb = 4'b0111;
      step();
      for (int i = 0; i < 6; i++) begin
         int e;
         e = i % 3;
         s_ack = 1'b1;
         check_grants("rr_seq");
         chk("rr_seq_const", 128'(r_grant), 128'(onehot(e)));
         chk("rr_seq_ack", 128'(r_ack), 128'(onehot(e)));
         step();
         m_cyc[e] = 1'b0; m_stb[e] = 1'b0; s_ack = 1'b0;
         check_grants("rr_hold");
         step();
         m_cyc[e] = 1'b1; m_stb[e] = 1'b1;
      end
      m_cyc = '0; m_stb = '0;
      step();
      check_grants("rr_end");
      step();
      check_grants("rr_idle");

      // Fixed priority: ports 1 and 3 together, then zero-bubble handoff to 3.
      m_cyc = 4'b1010; m_stb = 4'b1010;
      step();
      check_grants("fp_first");
      chk("fp_first_const", 128'(f_grant), 128'(4'b0010));
      m_cyc = 4'b1000; m_stb = 4'b1000;
      check_grants("fp_hold");
      chk("fp_hold_const", 128'(f_grant), 128'(4'b0010));
      step();
      check_grants("fp_handoff");
      chk("fp_handoff_const", 128'(f_grant), 128'(4'b1000));
      m_cyc = '0; m_stb = '0;
      step();
      check_grants("fp_idle");

      // Routing through port 2 with other ports carrying distinct junk.
      for (int k = 0; k < P; k++) begin
         m_adr[k*AW +: AW] = $urandom;
         m_dat[k*DW +: DW] = $urandom;
      end
      m_sel = 16'h5A5A;
      m_adr[2*AW +: AW] = 32'h1000_0040;
      m_dat[2*DW +: DW] = 32'hDEAD_BEEF;
      m_sel[2*SW +: SW] = 4'hF;
      m_we = 4'b0100; m_cyc = 4'b0100; m_stb = 4'b0100;
      step();
      check_grants("route");
      chk("route_adr", 128'(r_adr), 128'(32'h1000_0040));
      chk("route_dat", 128'(r_sdat), 128'(32'hDEAD_BEEF));
      chk("route_sel", 128'(r_sel), 128'(4'hF));
      chk("route_we", 128'(r_we), 128'(1));
      chk("route_stb", 128'(r_stb), 128'(1));
      s_ack = 1'b1; s_dat = 32'hCAFE_F00D;
      #1;
      chk("route_ack", 128'(r_ack), 128'(4'b0100));
      chk("route_err", 128'(r_err), 128'(0));
      chk("route_rdata", 128'(r_mdat), {4{32'hCAFE_F00D}});
      s_ack = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
      step();
      check_grants("route_idle");

      // Error and retry forwarding to port 0 only; ack+err pass through together.
      m_cyc = 4'b0001; m_stb = 4'b0001;
      step();
      check_grants("errrty");
      s_err = 1'b1;
      #1;
      chk("err_fwd", 128'({r_ack, r_err, r_rty}), 128'({4'b0000, 4'b0001, 4'b0000}));
      s_err = 1'b0; s_rty = 1'b1;
      #1;
      chk("rty_fwd", 128'({r_ack, r_err, r_rty}), 128'({4'b0000, 4'b0000, 4'b0001}));
      s_rty = 1'b0; s_ack = 1'b1; s_err = 1'b1;
      #1;
      chk("ackerr_fwd", 128'({r_ack, r_err, r_rty}), 128'({4'b0001, 4'b0001, 4'b0000}));
      s_ack = 1'b0; s_err = 1'b0; m_cyc = '0; m_stb = '0;
      step();
      check_grants("errrty_idle");

      // Watchdog: eight silent strobe cycles, fire in the ninth.
      m_cyc = 4'b0010; m_stb = 4'b0010;
      step();
      for (int n = 1; n <= TO; n++) begin
         check_grants("wd_wait");
         chk("wd_wait_to", 128'(r_to), 128'(0));
         chk("wd_wait_stb", 128'(r_stb), 128'(1));
         step();
      end
      s_ack = 1'b1;
      check_grants("wd_fire");
      chk("wd_fire_to", 128'(r_to), 128'(1));
      chk("wd_fire_err", 128'(r_err), 128'(4'b0010));
      chk("wd_fire_stb", 128'(r_stb), 128'(0));
      chk("wd_fire_ack", 128'(r_ack), 128'(0));
      chk("wd_fp_noerr", 128'(f_err), 128'(0));
      chk("wd_fp_ack", 128'(f_ack), 128'(4'b0010));
      step();
      s_ack = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         s_ack = (n == 7);
         check_grants("wd_ack7");
         chk("wd_ack7_to", 128'(r_to), 128'(0));
         step();
      end
      s_ack = 1'b0; m_cyc = '0; m_stb = '0;
      step();
      check_grants("wd_idle");

      // Asynchronous reset mid-transfer, then pointer restart at port 0.
      m_cyc = 4'b0001; m_stb = 4'b0001;
      step();
      check_grants("mid_a");
      m_cyc = 4'b0101; m_stb = 4'b0101;
      step();
      check_grants("mid_b");
      rst_n = 1'b0;
      #1;
      chk("mid_rst_grant", 128'(r_grant), 128'(0));
      chk("mid_rst_cyc", 128'(r_cyc), 128'(0));
      chk("mid_rst_fp_cyc", 128'(f_cyc), 128'(0));
      model_reset();
      #1;
      rst_n = 1'b1;
      step();
      check_grants("post_rst");
      chk("post_rst_ptr", 128'(r_grant), 128'(4'b0001));
      m_cyc = '0; m_stb = '0;
      step();
      check_grants("post_rst_idle");

      // Random traffic: reactive masters, slave terminates within 0..3 wait cycles.
      done = '0; lat = 0; lat_armed = 1'b0;
      for (int c = 0; c < 400; c++) begin
         step();
         for (int k = 0; k < P; k++) begin
            if (done[k]) begin
               m_cyc[k] = 1'b0; m_stb[k] = 1'b0;
            end else if (!m_cyc[k] && $urandom_range(0, 2) == 0) begin
               m_cyc[k] = 1'b1; m_stb[k] = 1'b1;
               m_we[k]  = 1'($urandom);
               m_adr[k*AW +: AW] = $urandom;
               m_dat[k*DW +: DW] = $urandom;
               m_sel[k*SW +: SW] = 4'($urandom);
            end
         end
         done = '0;
         s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
         s_dat = $urandom;
         if (g_rr >= 0 && m_stb[g_rr]) begin
            if (!lat_armed) begin
               lat = $urandom_range(0, 3);
               lat_armed = 1'b1;
            end
            if (lat == 0) begin
               r = $urandom_range(0, 15);
               if (r == 0) s_err = 1'b1;
               else if (r == 1) s_rty = 1'b1;
               else s_ack = 1'b1;
               done[g_rr] = 1'b1;
               lat_armed = 1'b0;
            end else begin
               lat--;
            end
         end
         exp_adr = (g_rr >= 0) ? m_adr[g_rr*AW +: AW] : '0;
         exp_dat = (g_rr >= 0) ? m_dat[g_rr*DW +: DW] : '0;
         exp_stb = (g_rr >= 0) ? m_stb[g_rr] : 1'b0;
         check_grants("rnd");
         chk("rnd_ack", 128'(r_ack), 128'(s_ack ? onehot(g_rr) : 4'b0));
         chk("rnd_err", 128'(r_err), 128'(s_err ? onehot(g_rr) : 4'b0));
         chk("rnd_rty", 128'(r_rty), 128'(s_rty ? onehot(g_rr) : 4'b0));
         chk("rnd_adr", 128'(r_adr), 128'(exp_adr));
         chk("rnd_wdat", 128'(r_sdat), 128'(exp_dat));
         chk("rnd_stb", 128'(r_stb), 128'(exp_stb));
         chk("rnd_rdat", r_mdat, {4{s_dat}});
         chk("rnd_to", 128'(r_to), 128'(0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
